// File: rtl/mix_char_feeder.sv
// Streams MIX words as ASCII characters to a UART transmitter, five characters
// per word, with a CR LF after each I/O block or every WORDS_PER_LINE words.
module mix_char_feeder #(
  parameter int unsigned WORDS_PER_LINE = 14
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [29:0] word_in,
  input  logic        word_valid,
  input  logic        block_end,
  output logic        word_ready,
  output logic [6:0]  tx_data,
  output logic        tx_load,
  input  logic        tx_ready,
  output logic        busy
);

  localparam int unsigned WordW = 30;
  localparam int unsigned CodeW = 6;
  localparam int unsigned CharW = 7;
  localparam int unsigned IdxW  = 3;
  localparam int unsigned CntW  = 5;

  localparam logic [CharW-1:0] AsciiCr = 7'h0D;
  localparam logic [CharW-1:0] AsciiLf = 7'h0A;
  localparam logic [IdxW-1:0]  LastIdx = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHAR,
    ST_CR,
    ST_LF
  } state_e;

  state_e            state_q, state_d;
  logic [WordW-1:0]  word_q, word_d;
  logic              blk_q, blk_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   cnt_inc_c;
  logic [CharW-1:0]  data_q, data_d;
  logic              load_q, load_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              consume_c;

  // MIX character code to ASCII; punctuation block and out-of-range codes decoded explicitly.
  function automatic logic [CharW-1:0] mix_to_ascii(input logic [CodeW-1:0] code);
    logic [CharW-1:0] c7;
    c7 = CharW'(code);
    if (code == 6'd0)       mix_to_ascii = 7'h20;
    else if (code <= 6'd9)  mix_to_ascii = c7 + 7'h40;
    else if (code == 6'd10) mix_to_ascii = 7'h7E;
    else if (code <= 6'd19) mix_to_ascii = c7 + 7'h3F;
    else if (code == 6'd20) mix_to_ascii = 7'h5B;
    else if (code == 6'd21) mix_to_ascii = 7'h23;
    else if (code <= 6'd29) mix_to_ascii = c7 + 7'h3D;
    else if (code <= 6'd39) mix_to_ascii = c7 + 7'h12;
    else begin
      case (code)
        6'd40:   mix_to_ascii = 7'h2E;
        6'd41:   mix_to_ascii = 7'h2C;
        6'd42:   mix_to_ascii = 7'h28;
        6'd43:   mix_to_ascii = 7'h29;
        6'd44:   mix_to_ascii = 7'h2B;
        6'd45:   mix_to_ascii = 7'h2D;
        6'd46:   mix_to_ascii = 7'h2A;
        6'd47:   mix_to_ascii = 7'h2F;
        6'd48:   mix_to_ascii = 7'h3D;
        6'd49:   mix_to_ascii = 7'h24;
        6'd50:   mix_to_ascii = 7'h3C;
        6'd51:   mix_to_ascii = 7'h3E;
        6'd52:   mix_to_ascii = 7'h40;
        6'd53:   mix_to_ascii = 7'h3B;
        6'd54:   mix_to_ascii = 7'h3A;
        6'd55:   mix_to_ascii = 7'h27;
        default: mix_to_ascii = 7'h3F;
      endcase
    end
  endfunction

  // Byte 1 sits in the most significant six bits.
  function automatic logic [CodeW-1:0] code_at(input logic [WordW-1:0] w,
                                               input logic [IdxW-1:0]  idx);
    case (idx)
      3'd0:    code_at = w[29:24];
      3'd1:    code_at = w[23:18];
      3'd2:    code_at = w[17:12];
      3'd3:    code_at = w[11:6];
      default: code_at = w[5:0];
    endcase
  endfunction

  assign consume_c = load_q & tx_ready;
  assign cnt_inc_c = cnt_q + CntW'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    blk_d   = blk_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    load_d  = load_q;

    case (state_q)
      ST_IDLE: begin
        if (ready_q && word_valid) begin
          word_d  = word_in;
          blk_d   = block_end;
          idx_d   = '0;
          data_d  = mix_to_ascii(code_at(word_in, 3'd0));
          load_d  = 1'b1;
          state_d = ST_CHAR;
        end
      end
      ST_CHAR: begin
        if (consume_c) begin
          if (idx_q == LastIdx) begin
            cnt_d = cnt_inc_c;
            if (blk_q || (cnt_inc_c == CntW'(WORDS_PER_LINE))) begin
              data_d  = AsciiCr;
              state_d = ST_CR;
            end else begin
              load_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end else begin
            idx_d  = idx_q + IdxW'(1);
            data_d = mix_to_ascii(code_at(word_q, idx_q + IdxW'(1)));
          end
        end
      end
      ST_CR: begin
        if (consume_c) begin
          data_d  = AsciiLf;
          state_d = ST_LF;
        end
      end
      ST_LF: begin
        if (consume_c) begin
          cnt_d   = '0;
          load_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        load_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      blk_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      blk_q   <= blk_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      load_q  <= load_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign word_ready = ready_q;
  assign tx_data    = data_q;
  assign tx_load    = load_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mix_char_feeder.sv
// Directed self-checking bench for mix_char_feeder: character decode, line
// breaking, transmitter back-pressure and mid-word reset.
module tb_mix_char_feeder;

  logic        clk;
  logic        resetn;
  logic [29:0] word_in;
  logic        word_valid;
  logic        block_end;
  logic        word_ready;
  logic [6:0]  tx_data;
  logic        tx_load;
  logic        tx_ready;
  logic        busy;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  logic [6:0] rx_q[$];
  logic [6:0] exp_q[$];

  localparam logic [29:0] HelloWord = 30'h814D350;

  mix_char_feeder #(.WORDS_PER_LINE(14)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .word_in    (word_in),
    .word_valid (word_valid),
    .block_end  (block_end),
    .word_ready (word_ready),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .tx_ready   (tx_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every character the transmitter consumes.
  always @(posedge clk) begin
    if (resetn && tx_load && tx_ready) rx_q.push_back(tx_data);
  end

  function automatic logic [29:0] pack(input logic [5:0] c1, input logic [5:0] c2,
                                       input logic [5:0] c3, input logic [5:0] c4,
                                       input logic [5:0] c5);
    return {c1, c2, c3, c4, c5};
  endfunction

  task automatic push_hello();
    exp_q.push_back(7'h48); exp_q.push_back(7'h45); exp_q.push_back(7'h4C);
    exp_q.push_back(7'h4C); exp_q.push_back(7'h4F);
  endtask

  task automatic push_crlf();
    exp_q.push_back(7'h0D); exp_q.push_back(7'h0A);
  endtask

  task automatic send_word(input logic [29:0] w, input logic be);
    int n;
    n = 0;
    while (word_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    assert_cnt++;
    if (word_ready !== 1'b1) begin
      fail_cnt++;
      $display("FAIL send_word_ready: word_ready=%b after %0d cycles, required 1", word_ready, n);
    end
    word_in    = w;
    block_end  = be;
    word_valid = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
    block_end  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(busy === 1'b0 && word_ready === 1'b1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    assert_cnt++;
    if (!(busy === 1'b0 && word_ready === 1'b1)) begin
      fail_cnt++;
      $display("FAIL wait_idle: busy=%b word_ready=%b after %0d cycles, required 0/1", busy, word_ready, n);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; word_valid = 1'b0; block_end = 1'b0; word_in = '0; tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    assert_cnt++; if (tx_load !== 1'b0) begin fail_cnt++; $display("FAIL reset_tx_load: got %b, required 0", tx_load); end
    assert_cnt++; if (tx_data !== 7'h00) begin fail_cnt++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
    assert_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy: got %b, required 0", busy); end
    assert_cnt++; if (word_ready !== 1'b0) begin fail_cnt++; $display("FAIL reset_word_ready: got %b, required 0", word_ready); end
    resetn = 1'b1;
    #1;
    assert_cnt++; if (word_ready !== 1'b0) begin fail_cnt++; $display("FAIL ready_before_edge: got %b, required 0", word_ready); end
    @(negedge clk);
    assert_cnt++; if (word_ready !== 1'b1) begin fail_cnt++; $display("FAIL ready_first_edge: got %b, required 1", word_ready); end
  endtask

  task automatic test_hello();
    rx_q.delete(); exp_q.delete();
    push_hello();
    send_word(HelloWord, 1'b0);
    wait_idle();
    assert_cnt++;
    if (rx_q.size() !== exp_q.size()) begin
      fail_cnt++; $display("FAIL hello_len: got %0d chars, required %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        assert_cnt++;
        if (rx_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL hello_char[%0d]: got %h, required %h", i, rx_q[i], exp_q[i]); end
      end
    end
    assert_cnt++; if (tx_load !== 1'b0) begin fail_cnt++; $display("FAIL hello_idle_load: got %b, required 0", tx_load); end
  endtask

  task automatic test_block_end();
    rx_q.delete(); exp_q.delete();
    push_hello(); push_crlf();
    send_word(HelloWord, 1'b1);
    wait_idle();
    assert_cnt++;
    if (rx_q.size() !== exp_q.size()) begin
      fail_cnt++; $display("FAIL block_len: got %0d chars, required %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        assert_cnt++;
        if (rx_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL block_char[%0d]: got %h, required %h", i, rx_q[i], exp_q[i]); end
      end
    end
    assert_cnt++; if (word_ready !== 1'b1) begin fail_cnt++; $display("FAIL block_ready: got %b, required 1", word_ready); end
  endtask

  task automatic test_line_wrap();
    rx_q.delete(); exp_q.delete();
    for (int w = 1; w <= 28; w++) begin
      push_hello();
      if (w == 14 || w == 28) push_crlf();
      send_word(HelloWord, (w == 28) ? 1'b1 : 1'b0);
      wait_idle();
    end
    assert_cnt++;
    if (rx_q.size() !== exp_q.size()) begin
      fail_cnt++; $display("FAIL wrap_len: got %0d chars, required %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        assert_cnt++;
        if (rx_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL wrap_char[%0d]: got %h, required %h", i, rx_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_stall();
    int bad;
    rx_q.delete(); exp_q.delete();
    push_hello();
    tx_ready = 1'b0;
    send_word(HelloWord, 1'b0);
    word_in = pack(6'd1, 6'd1, 6'd1, 6'd1, 6'd1);
    word_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      assert_cnt++;
      if (tx_load !== 1'b1 || tx_data !== 7'h48 || word_ready !== 1'b0 || busy !== 1'b1) begin
        fail_cnt++;
        if (bad < 3) $display("FAIL stall_hold[%0d]: load=%b data=%h ready=%b busy=%b, required 1/48/0/1",
                              c, tx_load, tx_data, word_ready, busy);
        bad++;
      end
    end
    word_valid = 1'b0;
    tx_ready = 1'b1;
    wait_idle();
    assert_cnt++;
    if (rx_q.size() !== exp_q.size()) begin
      fail_cnt++; $display("FAIL stall_len: got %0d chars, required %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        assert_cnt++;
        if (rx_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL stall_char[%0d]: got %h, required %h", i, rx_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_mapping();
    rx_q.delete(); exp_q.delete();
    // Line count is 1 here; four words keep it below the limit until block_end.
    send_word(pack(6'd30, 6'd39, 6'd10, 6'd21, 6'd56), 1'b0); wait_idle();
    exp_q.push_back(7'h30); exp_q.push_back(7'h39); exp_q.push_back(7'h7E); exp_q.push_back(7'h23); exp_q.push_back(7'h3F);
    send_word(pack(6'd0, 6'd9, 6'd11, 6'd20, 6'd22), 1'b0); wait_idle();
    exp_q.push_back(7'h20); exp_q.push_back(7'h49); exp_q.push_back(7'h4A); exp_q.push_back(7'h5B); exp_q.push_back(7'h53);
    send_word(pack(6'd29, 6'd40, 6'd47, 6'd55, 6'd63), 1'b0); wait_idle();
    exp_q.push_back(7'h5A); exp_q.push_back(7'h2E); exp_q.push_back(7'h2F); exp_q.push_back(7'h27); exp_q.push_back(7'h3F);
    send_word(pack(6'd49, 6'd52, 6'd48, 6'd1, 6'd19), 1'b1); wait_idle();
    exp_q.push_back(7'h24); exp_q.push_back(7'h40); exp_q.push_back(7'h3D); exp_q.push_back(7'h41); exp_q.push_back(7'h52);
    push_crlf();
    assert_cnt++;
    if (rx_q.size() !== exp_q.size()) begin
      fail_cnt++; $display("FAIL map_len: got %0d chars, required %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        assert_cnt++;
        if (rx_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL map_char[%0d]: got %h, required %h", i, rx_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [29:0] abcde;
    abcde = pack(6'd1, 6'd2, 6'd3, 6'd4, 6'd5);
    for (int w = 0; w < 3; w++) begin
      send_word(HelloWord, 1'b0);
      wait_idle();
    end
    rx_q.delete();
    tx_ready = 1'b0;
    send_word(abcde, 1'b0);
    tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tx_ready = 1'b0;
    assert_cnt++;
    if (rx_q.size() !== 2) begin
      fail_cnt++; $display("FAIL partial_len: got %0d chars, required 2", rx_q.size());
    end else begin
      assert_cnt++; if (rx_q[0] !== 7'h41) begin fail_cnt++; $display("FAIL partial_char0: got %h, required 41", rx_q[0]); end
      assert_cnt++; if (rx_q[1] !== 7'h42) begin fail_cnt++; $display("FAIL partial_char1: got %h, required 42", rx_q[1]); end
    end
    #2 resetn = 1'b0;
    #1;
    assert_cnt++; if (tx_load !== 1'b0) begin fail_cnt++; $display("FAIL midrst_tx_load: got %b, required 0", tx_load); end
    assert_cnt++; if (tx_data !== 7'h00) begin fail_cnt++; $display("FAIL midrst_tx_data: got %h, required 00", tx_data); end
    assert_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    rx_q.delete(); exp_q.delete();
    for (int w = 1; w <= 14; w++) begin
      exp_q.push_back(7'h41); exp_q.push_back(7'h42); exp_q.push_back(7'h43);
      exp_q.push_back(7'h44); exp_q.push_back(7'h45);
      if (w == 14) push_crlf();
      send_word(abcde, 1'b0);
      wait_idle();
    end
    assert_cnt++;
    if (rx_q.size() !== exp_q.size()) begin
      fail_cnt++; $display("FAIL restart_len: got %0d chars, required %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        assert_cnt++;
        if (rx_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL restart_char[%0d]: got %h, required %h", i, rx_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_hello();
    test_block_end();
    test_line_wrap();
    test_stall();
    test_mapping();
    test_reset_mid_word();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
